heap_arbiter: RTL and testbench

HEAP_ARBITER -- requirements
Module: heap_arbiter

---
 rtl/heap_arbiter.sv | 158 +++++++++++++++
 tb/tb_heap_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_arbiter.sv
// Round-robin arbiter that serializes push/pop requests from NREQ requesters
// onto one shared heap unit, with a per-operation watchdog.
//
// state | meaning
// IDLE  | waiting for any req_valid; grant chosen round-robin from ptr
// ISSUE | one cycle: req_ready[g] pulse, heap command pulse if op is possible
// WAIT  | heap working; done when idle (and pop result seen) or watchdog expires
// RESP  | one cycle: rsp_valid[g] with rsp_ok / rsp_data
module heap_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 32,
  parameter int HEAP_DEPTH = 11,
  parameter int TMO        = 63,
  localparam int CW        = $clog2(HEAP_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic               rsp_ok,
  output logic [DW-1:0]      rsp_data,
  output logic               h_push,
  output logic               h_pop,
  output logic [DW-1:0]      h_data,
  input  logic               h_busy,
  input  logic               h_out_v,
  input  logic [DW-1:0]      h_out_data,
  output logic [CW-1:0]      count
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TMO + 1);
  localparam logic [CW-1:0] FULL  = CW'(HEAP_DEPTH);
  localparam logic [WW-1:0] WLAST = WW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  g;
  logic [WW-1:0]  wdog;
  logic           op_pop;
  logic           op_go;
  logic           out_seen;
  logic [DW-1:0]  pop_q;

  logic           any_req;
  logic [GW-1:0]  rr_idx;
  logic           sel_op;
  logic [NREQ-1:0] rr_oh;
  logic [NREQ-1:0] g_oh;
  logic           done;

  // Descending scan so the candidate closest to ptr is the one that sticks.
  always_comb begin
    int idx;
    any_req = 1'b0;
    rr_idx  = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        any_req = 1'b1;
        rr_idx  = GW'(idx);
      end
    end
  end

  assign sel_op = req_op[rr_idx];
  assign rr_oh  = NREQ'(1) << rr_idx;
  assign g_oh   = NREQ'(1) << g;
  assign h_data = req_data[int'(g)*DW +: DW];

  // The first WAIT cycle is already one cycle past ISSUE; a pop result may
  // arrive in the same cycle the heap goes idle.
  assign done = !h_busy && (!op_pop || out_seen || h_out_v);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      g         <= '0;
      count     <= '0;
      wdog      <= '0;
      op_pop    <= 1'b0;
      op_go     <= 1'b0;
      out_seen  <= 1'b0;
      pop_q     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_ok    <= 1'b0;
      rsp_data  <= '0;
      h_push    <= 1'b0;
      h_pop     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            g         <= rr_idx;
            ptr       <= GW'((int'(rr_idx) + 1) % NREQ);
            op_pop    <= sel_op;
            op_go     <= sel_op ? (count != '0) : (count != FULL);
            req_ready <= rr_oh;
            h_push    <= !sel_op && (count != FULL);
            h_pop     <= sel_op && (count != '0);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          req_ready <= '0;
          h_push    <= 1'b0;
          h_pop     <= 1'b0;
          wdog      <= '0;
          out_seen  <= 1'b0;
          pop_q     <= '0;
          if (op_go) begin
            state <= WAIT;
          end else begin
            rsp_valid <= g_oh;
            rsp_ok    <= 1'b0;
            rsp_data  <= '0;
            state     <= RESP;
          end
        end
        WAIT: begin
          wdog <= wdog + WW'(1);
          if (op_pop && h_out_v && !out_seen) begin
            out_seen <= 1'b1;
            pop_q    <= h_out_data;
          end
          if (done) begin
            count     <= op_pop ? count - CW'(1) : count + CW'(1);
            rsp_valid <= g_oh;
            rsp_ok    <= 1'b1;
            rsp_data  <= op_pop ? (out_seen ? pop_q : h_out_data) : '0;
            state     <= RESP;
          end else if (wdog == WLAST) begin
            rsp_valid <= g_oh;
            rsp_ok    <= 1'b0;
            rsp_data  <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          rsp_ok    <= 1'b0;
          rsp_data  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_arbiter.sv
// Scoreboard bench for heap_arbiter: requester drivers, a behavioural heap
// unit, and a transaction-level reference model of arbitration and heap contents.
module tb_heap_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int HD   = 11;
  localparam int TMO  = 63;
  localparam int CW   = $clog2(HD + 1);

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid, req_op, req_ready, rsp_valid;
  logic [NREQ*DW-1:0] req_data;
  logic rsp_ok, h_push, h_pop, h_busy, h_out_v;
  logic [DW-1:0] rsp_data, h_data, h_out_data;
  logic [CW-1:0] count;

  heap_arbiter #(.NREQ(NREQ), .DW(DW), .HEAP_DEPTH(HD), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ok(rsp_ok), .rsp_data(rsp_data), .h_push(h_push), .h_pop(h_pop),
    .h_data(h_data), .h_busy(h_busy), .h_out_v(h_out_v),
    .h_out_data(h_out_data), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    logic          op;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    logic [NREQ-1:0] who;
    logic            ok;
    logic [DW-1:0]   data;
    int              cnt;
    int              rdy;
    int              lat;
    bit              exact;
  } exp_t;

  op_t  rq [NREQ][$];
  op_t  cur [NREQ];
  logic [NREQ-1:0] pres = '0, ghost = '0, acc = '0, prev_v = '0;
  exp_t sb[$];
  int unsigned ref_h[$];
  int   ptr_m = 0;
  bit   hang = 1'b0;
  int   lat_fixed = 3;
  int   n_cmp = 0, n_bad = 0;

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic add(input int i, input logic op, input logic [DW-1:0] d);
    op_t o;
    o.op = op;
    o.data = d;
    rq[i].push_back(o);
  endtask

  // Requester drivers: hold each op until its acceptance pulse was seen.
  initial begin
    req_valid = '0; req_op = '0; req_data = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          pres[i] = 1'b0;
          acc[i]  = 1'b0;
        end
        if (!pres[i] && rq[i].size() > 0 && !reset) begin
          cur[i]  = rq[i].pop_front();
          pres[i] = 1'b1;
        end
        req_op[i] = pres[i] ? cur[i].op : 1'b0;
        req_data[i*DW +: DW] = pres[i] ? cur[i].data : '0;
      end
      req_valid = pres | ghost;
    end
  end

  // Heap unit stand-in: max-heap contents, busy for a latency after each command.
  initial begin
    int unsigned hm[$];
    int bcnt, out_at, mi;
    bit popp;
    bcnt = 0; out_at = 0; popp = 0;
    h_busy = 1'b0; h_out_v = 1'b0; h_out_data = '0;
    forever begin
      @(negedge clk);
      h_out_v = 1'b0;
      h_out_data = $urandom;
      if (reset) begin
        hm.delete(); bcnt = 0; popp = 0; h_busy = 1'b0;
      end else begin
        if (bcnt > 0) bcnt--;
        if (popp && bcnt <= out_at) begin
          mi = 0;
          for (int k = 1; k < hm.size(); k++) if (hm[k] > hm[mi]) mi = k;
          h_out_v = 1'b1;
          h_out_data = (hm.size() > 0) ? hm[mi] : 32'hDEAD_BEEF;
          if (hm.size() > 0) hm.delete(mi);
          popp = 0;
        end
        if (!hang && (h_push || h_pop)) begin
          bcnt = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 5);
          if (h_push) hm.push_back(h_data);
          if (h_pop) begin popp = 1; out_at = $urandom_range(0, 1); end
        end
        h_busy = hang || (bcnt > 0);
      end
    end
  end

  // Acceptance: check arbitration and command, then push the expected response.
  task automatic accept();
    int w, i, mi;
    exp_t e;
    logic [1:0] cmd;
    check("ready_onehot", $countones(req_ready), 1);
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && prev_v[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
    i = 0;
    for (int k = NREQ - 1; k >= 0; k--) if (req_ready[k]) i = k;
    check("rr_grant", i, w);
    check("ready_unexpected", pres[i], 1);
    if (!pres[i]) return;
    ptr_m  = (i + 1) % NREQ;
    acc[i] = 1'b1;
    e.who = req_ready; e.ok = 1'b0; e.data = '0; e.rdy = cyc;
    e.lat = 1; e.exact = 1'b1; cmd = 2'b00;
    if (!cur[i].op) begin
      if (ref_h.size() < HD) begin
        cmd = 2'b10;
        if (hang) e.lat = TMO + 1;
        else begin
          ref_h.push_back(cur[i].data);
          e.ok = 1'b1;
        end
      end
    end else if (ref_h.size() > 0) begin
      cmd = 2'b01;
      if (hang) e.lat = TMO + 1;
      else begin
        mi = 0;
        for (int k = 1; k < ref_h.size(); k++) if (ref_h[k] > ref_h[mi]) mi = k;
        e.ok = 1'b1;
        e.data = ref_h[mi];
        ref_h.delete(mi);
      end
    end
    if (e.ok) begin
      e.lat   = (lat_fixed != 0) ? lat_fixed + 1 : 2;
      e.exact = (lat_fixed != 0);
    end
    e.cnt = ref_h.size();
    check("heap_cmd", {h_push, h_pop}, cmd);
    if (h_push) check("h_data", h_data, cur[i].data);
    sb.push_back(e);
  endtask

  task automatic respond();
    exp_t e;
    if (sb.size() == 0) begin
      check("rsp_unexpected", $countones(rsp_valid), 0);
      return;
    end
    e = sb.pop_front();
    check("rsp_who", rsp_valid, e.who);
    check("rsp_ok", rsp_ok, e.ok);
    check("rsp_data", rsp_data, e.data);
    check("count", count, e.cnt);
    if (e.exact) check("rsp_latency", cyc - e.rdy, e.lat);
    else check("rsp_latency_min", (cyc - e.rdy) >= e.lat, 1);
  endtask

  // Monitor: everything sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_v = '0;
    end else begin
      if (req_ready != '0) accept();
      else if (h_push || h_pop) check("heap_cmd_stray", {h_push, h_pop}, 0);
      if (rsp_valid != '0) respond();
      else if (rsp_ok || rsp_data != '0) check("rsp_idle_zero", {rsp_ok, rsp_data}, 0);
      prev_v = req_valid;
    end
  end

  function automatic bit tb_idle();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 1'b0;
    return (pres == '0) && (sb.size() == 0);
  endfunction

  task automatic drain(input int max);
    int n;
    n = 0;
    while (n < max && !tb_idle()) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", n < max, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_ready(input int i, input int max);
    int n;
    n = 0;
    while (n < max && !req_ready[i]) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", n < max, 1);
  endtask

  task automatic check_rst_outputs();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_ok", rsp_ok, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_h_cmd", {h_push, h_pop}, 0);
    check("rst_count", count, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    pres = '0; acc = '0; ghost = '0;
    sb.delete(); ref_h.delete(); ptr_m = 0;
    repeat (2) begin
      @(negedge clk);
      check_rst_outputs();
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, pb, r;
    logic [DW-1:0] vals [12];
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_rst_outputs();
    end
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Single push with a 3-cycle heap
    lat_fixed = 3;
    add(0, 1'b0, 5);
    drain(200);

    // Simultaneous pushes from reset, then a lone pop, then all again
    do_reset();
    for (int i = 0; i < NREQ; i++) add(i, 1'b0, 10 + i);
    drain(200);
    add(2, 1'b1, 0);
    drain(200);
    for (int i = 0; i < NREQ; i++) add(i, 1'b0, 20 + i);
    drain(200);

    // Pop from an empty heap is rejected
    do_reset();
    add(1, 1'b1, 0);
    drain(100);

    // Fill to capacity, overflow push, pop returns the maximum
    do_reset();
    vals = '{3, 9, 7, 1, 2, 4, 5, 6, 8, 0, 2, 4};
    for (int k = 0; k < 12; k++) add(1, 1'b0, vals[k]);
    add(1, 1'b1, 0);
    drain(500);

    // Heap never goes idle: watchdog expiry for push and pop
    hang = 1'b1;
    add(3, 1'b0, 77);
    add(0, 1'b1, 0);
    drain(400);
    hang = 1'b0;

    // Requester 1 raises and drops valid while an op is in flight
    lat_fixed = 6;
    add(0, 1'b1, 0);
    wait_ready(0, 50);
    @(posedge clk);
    #2;
    ghost = 4'b0010;
    repeat (2) @(posedge clk);
    #2;
    ghost = '0;
    drain(200);

    // Reset in the middle of WAIT abandons the op
    do_reset();
    hang = 1'b1;
    add(0, 1'b0, 55);
    wait_ready(0, 50);
    repeat (5) @(posedge clk);
    do_reset();
    hang = 1'b0;
    lat_fixed = 2;
    add(2, 1'b0, 42);
    drain(200);

    // Randomized traffic with random heap latency
    lat_fixed = 0;
    for (int rd = 0; rd < 30; rd++) begin
      n  = $urandom_range(1, 10);
      pb = (rd < 15) ? 30 : 65;
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, NREQ - 1);
        add(r, ($urandom_range(0, 99) < pb), $urandom_range(0, 999));
      end
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    drain(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
